// File: rtl/mgr_array_sync_barrier.sv
// Barrier controller for the manager array: collects arrivals from the
// enabled managers, releases them together, then drains before re-arming.
module mgr_array_sync_barrier #(
   parameter int NUM_OF_MGR = 64,
   parameter int MGR_ID_W   = 6,
   parameter int TIMEOUT_W  = 16
) (
   input  logic                  clk,
   input  logic                  reset_poweron,
   input  logic [NUM_OF_MGR-1:0] cfg__enable_mask,
   input  logic [TIMEOUT_W-1:0]  cfg__timeout,
   input  logic                  cfg__err_clear,
   input  logic [NUM_OF_MGR-1:0] mgr__sys__allSynchronized,
   output logic [NUM_OF_MGR-1:0] sys__mgr__thisSynchronized,
   output logic [NUM_OF_MGR-1:0] sys__mgr__ready,
   output logic [NUM_OF_MGR-1:0] sys__mgr__complete,
   output logic [7:0]            sync__epoch,
   output logic                  sync__timeout_err,
   output logic [MGR_ID_W:0]     sync__missing_cnt,
   output logic [MGR_ID_W-1:0]   sync__missing_first_id
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_RELEASE,
      S_HOLD,
      S_ERROR
   } state_t;

   state_t state, state_nx;

   logic [NUM_OF_MGR-1:0] mask_r, mask_nx;
   logic [NUM_OF_MGR-1:0] arrived_r, arrived_nx;
   logic [NUM_OF_MGR-1:0] mask, arr, arrived_next, miss_vec;
   logic [TIMEOUT_W-1:0]  cnt, cnt_nx;
   logic                  all_in;
   logic                  rel_entry, err_entry;
   logic [MGR_ID_W:0]     miss_cnt_c;
   logic [MGR_ID_W-1:0]   miss_id_c;

   always_comb begin
      mask         = (state == S_IDLE) ? cfg__enable_mask : mask_r;
      arr          = mgr__sys__allSynchronized & mask;
      arrived_next = arrived_r | arr;
      all_in       = ((arrived_next & mask) == mask);
      miss_vec     = mask_r & ~arrived_next;
   end

   // Diagnostics reflect the arrival vector as it will be frozen in ERROR
   always_comb begin
      miss_cnt_c = '0;
      miss_id_c  = '0;
      for (int i = 0; i < NUM_OF_MGR; i++)
         miss_cnt_c = miss_cnt_c + (MGR_ID_W+1)'(miss_vec[i]);
      for (int i = NUM_OF_MGR-1; i >= 0; i--)
         if (miss_vec[i]) miss_id_c = MGR_ID_W'(i);
   end

   always_comb begin
      state_nx   = state;
      mask_nx    = mask_r;
      arrived_nx = arrived_r;
      cnt_nx     = cnt;
      unique case (state)
         S_IDLE: begin
            if (cfg__enable_mask != '0 && arr != '0) begin
               mask_nx    = cfg__enable_mask;
               arrived_nx = arr;
               cnt_nx     = '0;
               state_nx   = all_in ? S_RELEASE : S_COLLECT;
            end
         end
         S_COLLECT: begin
            arrived_nx = arrived_next;
            if (all_in)
               state_nx = S_RELEASE;
            else if (cfg__timeout != '0 &&
                     cnt == cfg__timeout - TIMEOUT_W'(1))
               state_nx = S_ERROR;
            else
               cnt_nx = cnt + TIMEOUT_W'(1);
         end
         S_RELEASE: begin
            state_nx   = S_HOLD;
            arrived_nx = '0;
         end
         S_HOLD: begin
            if ((mgr__sys__allSynchronized & mask_r) == '0) begin
               state_nx = S_IDLE;
               mask_nx  = '0;
            end
         end
         S_ERROR: begin
            if (cfg__err_clear) begin
               state_nx   = S_IDLE;
               arrived_nx = '0;
               mask_nx    = '0;
               cnt_nx     = '0;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign rel_entry = (state_nx == S_RELEASE) && (state != S_RELEASE);
   assign err_entry = (state == S_COLLECT) && (state_nx == S_ERROR);

   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         state     <= S_IDLE;
         mask_r    <= '0;
         arrived_r <= '0;
         cnt       <= '0;
      end else begin
         state     <= state_nx;
         mask_r    <= mask_nx;
         arrived_r <= arrived_nx;
         cnt       <= cnt_nx;
      end
   end

   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         sync__epoch            <= '0;
         sync__timeout_err      <= 1'b0;
         sync__missing_cnt      <= '0;
         sync__missing_first_id <= '0;
      end else if (rel_entry) begin
         sync__epoch            <= sync__epoch + 8'd1;
         sync__timeout_err      <= 1'b0;
         sync__missing_cnt      <= '0;
         sync__missing_first_id <= '0;
      end else if (err_entry) begin
         sync__timeout_err      <= 1'b1;
         sync__missing_cnt      <= miss_cnt_c;
         sync__missing_first_id <= miss_id_c;
      end
   end

   assign sys__mgr__thisSynchronized = arrived_r & mask_r;
   assign sys__mgr__ready    = (state == S_RELEASE) ? mask_r : '0;
   assign sys__mgr__complete = (state == S_HOLD) ?
                               (mask_r & mgr__sys__allSynchronized) : '0;

endmodule

// File: tb/tb_mgr_array_sync_barrier.sv
// Directed bench for mgr_array_sync_barrier with four managers.
module tb_mgr_array_sync_barrier;

   localparam int N  = 4;
   localparam int IW = 2;
   localparam int TW = 16;

   logic          clk = 1'b0;
   logic          reset_poweron;
   logic [N-1:0]  cfg__enable_mask;
   logic [TW-1:0] cfg__timeout;
   logic          cfg__err_clear;
   logic [N-1:0]  alls;
   logic [N-1:0]  this_sync, ready, complete;
   logic [7:0]    epoch;
   logic          terr;
   logic [IW:0]   mcnt;
   logic [IW-1:0] mid;

   int n_cmp = 0;
   int n_err = 0;

   mgr_array_sync_barrier #(
      .NUM_OF_MGR(N), .MGR_ID_W(IW), .TIMEOUT_W(TW)
   ) dut (
      .clk                        (clk),
      .reset_poweron              (reset_poweron),
      .cfg__enable_mask           (cfg__enable_mask),
      .cfg__timeout               (cfg__timeout),
      .cfg__err_clear             (cfg__err_clear),
      .mgr__sys__allSynchronized  (alls),
      .sys__mgr__thisSynchronized (this_sync),
      .sys__mgr__ready            (ready),
      .sys__mgr__complete         (complete),
      .sync__epoch                (epoch),
      .sync__timeout_err          (terr),
      .sync__missing_cnt          (mcnt),
      .sync__missing_first_id     (mid)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_poweron    = 1'b0;
      cfg__enable_mask = '0;
      cfg__timeout     = '0;
      cfg__err_clear   = 1'b0;
      alls             = '0;
      step();
      step();
      n_cmp++;
      if (this_sync !== 4'h0) begin
         n_err++;
         $display("FAIL reset_this: got %h want 0", this_sync);
      end
      n_cmp++;
      if (ready !== 4'h0 || complete !== 4'h0) begin
         n_err++;
         $display("FAIL reset_rdy_cmp: got %h/%h want 0/0", ready, complete);
      end
      n_cmp++;
      if ({epoch, terr, mcnt, mid} !== '0) begin
         n_err++;
         $display("FAIL reset_diag: got %h %b %h %h want 0", epoch, terr, mcnt, mid);
      end
      #2 reset_poweron = 1'b1;
      step();
   endtask

   task automatic test_basic();
      logic [N-1:0] exp_this [9];
      logic [N-1:0] exp_rdy  [9];
      exp_this = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h3, 4'h3, 4'hB, 4'h0};
      exp_rdy  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hB, 4'h0};
      cfg__enable_mask = 4'b1011;
      cfg__timeout     = '0;
      for (int c = 0; c < 9; c++) begin
         alls[0] = (c >= 2);
         alls[1] = (c >= 5);
         alls[3] = (c >= 7);
         alls[2] = c[0];
         step();
         n_cmp++;
         if (this_sync !== exp_this[c]) begin
            n_err++;
            $display("FAIL basic_this c%0d: got %h want %h", c, this_sync, exp_this[c]);
         end
         n_cmp++;
         if (ready !== exp_rdy[c]) begin
            n_err++;
            $display("FAIL basic_ready c%0d: got %h want %h", c, ready, exp_rdy[c]);
         end
      end
      n_cmp++;
      if (complete !== 4'hB) begin
         n_err++;
         $display("FAIL basic_complete: got %h want b", complete);
      end
      alls = '0;
      step();
      n_cmp++;
      if (epoch !== 8'd1 || complete !== 4'h0) begin
         n_err++;
         $display("FAIL basic_epoch: got %0d/%h want 1/0", epoch, complete);
      end
   endtask

   task automatic test_same_cycle();
      cfg__enable_mask = 4'hF;
      alls = 4'hF;
      step();
      n_cmp++;
      if (ready !== 4'hF || epoch !== 8'd2) begin
         n_err++;
         $display("FAIL same_ready: got %h/%0d want f/2", ready, epoch);
      end
      step();
      n_cmp++;
      if (ready !== 4'h0 || complete !== 4'hF) begin
         n_err++;
         $display("FAIL same_hold: got %h/%h want 0/f", ready, complete);
      end
      alls = '0;
      step();
   endtask

   task automatic test_timeout();
      int bad_rdy = 0;
      cfg__enable_mask = 4'hF;
      cfg__timeout     = 16'd10;
      alls = 4'b0101;
      for (int s = 1; s <= 10; s++) begin
         step();
         if (ready !== 4'h0) bad_rdy++;
      end
      n_cmp++;
      if (terr !== 1'b0 || this_sync !== 4'h5) begin
         n_err++;
         $display("FAIL to_early: got err=%b this=%h want 0/5", terr, this_sync);
      end
      step();
      if (ready !== 4'h0) bad_rdy++;
      n_cmp++;
      if (terr !== 1'b1 || mcnt !== 3'd2 || mid !== 2'd1) begin
         n_err++;
         $display("FAIL to_diag: got %b %0d %0d want 1 2 1", terr, mcnt, mid);
      end
      n_cmp++;
      if (bad_rdy !== 0) begin
         n_err++;
         $display("FAIL to_noready: got %0d pulses want 0", bad_rdy);
      end
      step();
      n_cmp++;
      if (terr !== 1'b1 || ready !== 4'h0) begin
         n_err++;
         $display("FAIL to_stay: got %b/%h want 1/0", terr, ready);
      end
      alls = '0;
      cfg__err_clear = 1'b1;
      step();
      cfg__err_clear = 1'b0;
      step();
      n_cmp++;
      if (this_sync !== 4'h0 || terr !== 1'b1 || epoch !== 8'd2 || mcnt !== 3'd2) begin
         n_err++;
         $display("FAIL to_clear: got %h %b %0d %0d want 0 1 2 2", this_sync, terr, epoch, mcnt);
      end
   endtask

   task automatic test_edge_timeout();
      cfg__enable_mask = 4'hF;
      cfg__timeout     = 16'd4;
      alls = 4'b0001;
      for (int s = 0; s < 4; s++) step();
      alls = 4'hF;
      step();
      n_cmp++;
      if (ready !== 4'hF || terr !== 1'b0 || mcnt !== 3'd0 || epoch !== 8'd3) begin
         n_err++;
         $display("FAIL edge_to: got %h %b %0d %0d want f 0 0 3", ready, terr, mcnt, epoch);
      end
      step();
      alls = '0;
      step();
      cfg__timeout = '0;
   endtask

   task automatic test_drop_hold();
      cfg__enable_mask = 4'hF;
      alls = 4'b0001;
      step();
      alls = 4'b0000;
      step();
      n_cmp++;
      if (this_sync !== 4'h1) begin
         n_err++;
         $display("FAIL drop_sticky: got %h want 1", this_sync);
      end
      alls = 4'b0110;
      step();
      n_cmp++;
      if (this_sync !== 4'h7) begin
         n_err++;
         $display("FAIL drop_this: got %h want 7", this_sync);
      end
      alls = 4'b1100;
      step();
      n_cmp++;
      if (ready !== 4'hF || epoch !== 8'd4) begin
         n_err++;
         $display("FAIL drop_release: got %h/%0d want f/4", ready, epoch);
      end
      alls = 4'b0100;
      for (int s = 0; s < 3; s++) begin
         step();
         n_cmp++;
         if (complete !== 4'h4 || ready !== 4'h0) begin
            n_err++;
            $display("FAIL hold_cmp s%0d: got %h/%h want 4/0", s, complete, ready);
         end
      end
      alls = '0;
      step();
      step();
      n_cmp++;
      if (epoch !== 8'd4 || this_sync !== 4'h0 || complete !== 4'h0) begin
         n_err++;
         $display("FAIL hold_exit: got %0d %h %h want 4 0 0", epoch, this_sync, complete);
      end
   endtask

   task automatic one_barrier();
      alls = 4'hF;
      step();
      step();
      alls = '0;
      step();
   endtask

   task automatic test_epoch_wrap();
      cfg__enable_mask = 4'hF;
      for (int b = 0; b < 251; b++) one_barrier();
      n_cmp++;
      if (epoch !== 8'd255) begin
         n_err++;
         $display("FAIL epoch_255: got %0d want 255", epoch);
      end
      one_barrier();
      n_cmp++;
      if (epoch !== 8'd0) begin
         n_err++;
         $display("FAIL epoch_wrap: got %0d want 0", epoch);
      end
   endtask

   task automatic test_reset_mid();
      int bad_rdy = 0;
      cfg__enable_mask = 4'hF;
      cfg__timeout     = 16'd10;
      alls = 4'b0001;
      step();
      alls = 4'b0011;
      step();
      n_cmp++;
      if (this_sync !== 4'h3) begin
         n_err++;
         $display("FAIL rst_pre: got %h want 3", this_sync);
      end
      alls = 4'hF;
      reset_poweron = 1'b0;
      #1;
      n_cmp++;
      if ({this_sync, ready, complete, epoch, terr, mcnt, mid} !== '0) begin
         n_err++;
         $display("FAIL rst_async: got %h %h %h %0d want all 0", this_sync, ready, complete, epoch);
      end
      step();
      if (ready !== 4'h0) bad_rdy++;
      alls = '0;
      #2 reset_poweron = 1'b1;
      for (int s = 0; s < 3; s++) begin
         step();
         if (ready !== 4'h0 || this_sync !== 4'h0) bad_rdy++;
      end
      n_cmp++;
      if (bad_rdy !== 0) begin
         n_err++;
         $display("FAIL rst_noready: got %0d bad cycles want 0", bad_rdy);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_same_cycle();
      test_timeout();
      test_edge_timeout();
      test_drop_hold();
      test_epoch_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
